// File: rtl/rib_arb_if.sv
// rtl/rib_arb_if.sv - RIB shared-bus signal bundle between masters, slaves and the arbiter
interface rib_arb_if #(
  parameter int NUM_M = 4,
  parameter int NUM_S = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic [NUM_M-1:0]    m_req_i;
  logic [NUM_M-1:0]    m_we_i;
  logic [NUM_M*AW-1:0] m_addr_i;
  logic [NUM_M*DW-1:0] m_data_i;
  logic [NUM_M*DW-1:0] m_data_o;
  logic [NUM_M-1:0]    m_gnt_o;
  logic [NUM_M-1:0]    m_hold_o;
  logic [NUM_S*AW-1:0] s_addr_o;
  logic [NUM_S*DW-1:0] s_data_o;
  logic [NUM_S-1:0]    s_we_o;
  logic [NUM_S*DW-1:0] s_data_i;
  logic                err_o;
  logic [AW-1:0]       err_addr_o;
  logic [7:0]          err_cnt_o;

  modport master (
    output m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i,
    input  m_data_o, m_gnt_o, m_hold_o, s_addr_o, s_data_o, s_we_o,
    input  err_o, err_addr_o, err_cnt_o
  );

  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i,
    output m_data_o, m_gnt_o, m_hold_o, s_addr_o, s_data_o, s_we_o,
    output err_o, err_addr_o, err_cnt_o
  );
endinterface

// File: rtl/rib_arb.sv
// rtl/rib_arb.sv - NUM_M x NUM_S shared-bus arbiter with fixed-priority or round-robin/tenure grant
module rib_arb #(
  parameter int NUM_M      = 4,
  parameter int NUM_S      = 8,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int SEL_W      = 4,
  parameter int ARB_MODE   = 0,
  parameter int MAX_TENURE = 8
) (
  input logic     clk,
  input logic     rst,
  rib_arb_if.slave bus
);
  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [7:0]      tenure_q, tenure_d;

  logic [NUM_M-1:0] req, rot;
  logic [MW-1:0]    fix_idx, off, gnt_idx;
  logic [MW:0]      sum;
  logic             gnt_vld, others, keep;
  logic [AW-1:0]    addr_g, addr_off;
  logic [DW-1:0]    wdata_g, rdata;
  logic             we_g, mapped;
  logic [SEL_W-1:0] sel;

  function automatic logic [MW-1:0] inc_wrap(input logic [MW-1:0] v);
    return (int'(v) == NUM_M - 1) ? '0 : v + 1'b1;
  endfunction

  // Reset gates requests so the grant and slave strobes drop asynchronously.
  assign req = rst ? '0 : bus.m_req_i;

  always_comb begin
    gnt_vld = |req;
    fix_idx = '0;
    for (int i = 0; i < NUM_M; i++)
      if (req[i]) fix_idx = MW'(i);
    rot = NUM_M'({req, req} >> rr_ptr_q);
    off = '0;
    for (int i = NUM_M - 1; i >= 0; i--)
      if (rot[i]) off = MW'(i);
    sum = {1'b0, rr_ptr_q} + {1'b0, off};
    if (sum >= (MW+1)'(NUM_M)) sum = sum - (MW+1)'(NUM_M);
    others = |(req & ~(NUM_M'(1) << owner_q));
    keep = (state_q == ST_OWNED) && req[owner_q] &&
           ((tenure_q < 8'(MAX_TENURE)) || !others);
    // While owned rr_ptr is owner+1, so one scan covers idle, release and expiry.
    if (ARB_MODE == 0)  gnt_idx = fix_idx;
    else if (keep)      gnt_idx = owner_q;
    else                gnt_idx = sum[MW-1:0];
  end

  always_comb begin
    addr_g  = '0;
    wdata_g = '0;
    we_g    = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt_vld && gnt_idx == MW'(i)) begin
        addr_g  = bus.m_addr_i[i*AW +: AW];
        wdata_g = bus.m_data_i[i*DW +: DW];
        we_g    = bus.m_we_i[i];
      end
    end
    sel      = addr_g[AW-1 -: SEL_W];
    mapped   = gnt_vld && (int'(sel) < NUM_S);
    addr_off = addr_g;
    addr_off[AW-1 -: SEL_W] = '0;
  end

  always_comb begin
    bus.m_gnt_o  = gnt_vld ? (NUM_M'(1) << gnt_idx) : '0;
    bus.m_hold_o = bus.m_req_i & ~bus.m_gnt_o;
    bus.s_addr_o = {NUM_S{addr_off}};
    bus.s_data_o = {NUM_S{wdata_g}};
    bus.s_we_o   = '0;
    rdata        = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (mapped && sel == SEL_W'(s)) begin
        bus.s_we_o[s] = we_g;
        rdata         = bus.s_data_i[s*DW +: DW];
      end
    end
    bus.m_data_o = '0;
    for (int i = 0; i < NUM_M; i++)
      if (gnt_vld && gnt_idx == MW'(i)) bus.m_data_o[i*DW +: DW] = rdata;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    tenure_d = tenure_q;
    if (ARB_MODE != 0) begin
      if (!gnt_vld) begin
        state_d  = ST_IDLE;
        tenure_d = '0;
      end else if (state_q == ST_OWNED && gnt_idx == owner_q) begin
        if (tenure_q < 8'(MAX_TENURE)) tenure_d = tenure_q + 8'd1;
      end else begin
        state_d  = ST_OWNED;
        owner_d  = gnt_idx;
        rr_ptr_d = inc_wrap(gnt_idx);
        tenure_d = 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      tenure_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      tenure_q <= tenure_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.err_o      <= 1'b0;
      bus.err_addr_o <= '0;
      bus.err_cnt_o  <= '0;
    end else begin
      bus.err_o <= gnt_vld && !mapped;
      if (gnt_vld && !mapped) begin
        bus.err_addr_o <= addr_g;
        if (bus.err_cnt_o != 8'hFF) bus.err_cnt_o <= bus.err_cnt_o + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_rib_arb.sv
// tb/tb_rib_arb.sv - self-checking bench for rib_arb in fixed and round-robin modes
module tb_rib_arb;
  localparam int NM = 4;
  localparam int NS = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM-1:0]    req, we;
  logic [NM*AW-1:0] addr;
  logic [NM*DW-1:0] wdata;
  logic [NS*DW-1:0] sdata;

  rib_arb_if #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW)) bf ();
  rib_arb_if #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW)) br ();

  assign bf.m_req_i = req;   assign br.m_req_i = req;
  assign bf.m_we_i = we;     assign br.m_we_i = we;
  assign bf.m_addr_i = addr; assign br.m_addr_i = addr;
  assign bf.m_data_i = wdata; assign br.m_data_i = wdata;
  assign bf.s_data_i = sdata; assign br.s_data_i = sdata;

  rib_arb #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .ARB_MODE(0), .MAX_TENURE(3))
    u_fix (.clk(clk), .rst(rst), .bus(bf));
  rib_arb #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .ARB_MODE(1), .MAX_TENURE(3))
    u_rr (.clk(clk), .rst(rst), .bus(br));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Reference model state: round-robin owner/run length/pointer, and per-DUT error registers.
  int rr_own, rr_run, rr_ptr;
  int e_p[2], e_c[2];
  logic [31:0] e_a[2];

  task automatic model_reset();
    rr_own = -1; rr_run = 0; rr_ptr = 0;
    for (int d = 0; d < 2; d++) begin e_p[d] = 0; e_c[d] = 0; e_a[d] = '0; end
  endtask

  function automatic int fix_expect(input logic [3:0] r);
    int g = -1;
    for (int k = 0; k < NM; k++) if (r[k]) g = k;
    return g;
  endfunction

  function automatic int rr_expect(input logic [3:0] r);
    bit oth = 0;
    for (int k = 0; k < NM; k++) if (r[k] && k != rr_own) oth = 1;
    if (rr_own >= 0 && r[rr_own] && (rr_run < 3 || !oth)) return rr_own;
    for (int i = 0; i < NM; i++) if (r[(rr_ptr + i) % NM]) return (rr_ptr + i) % NM;
    return -1;
  endfunction

  task automatic rr_commit(input int g);
    if (g < 0) begin rr_own = -1; rr_run = 0; end
    else if (g == rr_own) begin if (rr_run < 3) rr_run++; end
    else begin rr_own = g; rr_run = 1; rr_ptr = (g + 1) % NM; end
  endtask

  task automatic err_commit(input int d, input int g);
    logic [31:0] a;
    e_p[d] = 0;
    if (g >= 0) begin
      a = addr[g*AW +: AW];
      if (a[31:28] >= NS) begin
        e_p[d] = 1; e_a[d] = a;
        if (e_c[d] < 255) e_c[d]++;
      end
    end
  endtask

  task automatic check_bus(input string t, input int g, input logic [3:0] a_gnt, input logic [3:0] a_hold,
                           input logic [7:0] a_swe, input logic [31:0] a_sa, input logic [31:0] a_sd,
                           input logic [127:0] a_md);
    logic [3:0] e_gnt = '0;
    logic [7:0] e_swe = '0;
    logic [31:0] a = '0, e_sd = '0;
    logic [127:0] e_md = '0;
    int s;
    if (g >= 0) begin
      e_gnt = 4'(1 << g);
      a = addr[g*AW +: AW];
      e_sd = wdata[g*DW +: DW];
      s = int'(a[31:28]);
      if (s < NS) begin
        if (we[g]) e_swe = 8'(1 << s);
        e_md[g*DW +: DW] = sdata[s*DW +: DW];
      end
    end
    chk({t, "_gnt"}, a_gnt, e_gnt);
    chk({t, "_hold"}, a_hold, req & ~e_gnt);
    chk({t, "_swe"}, a_swe, e_swe);
    chk({t, "_saddr"}, a_sa, {4'h0, a[27:0]});
    chk({t, "_sdata"}, a_sd, e_sd);
    chk({t, "_mdata"}, a_md, e_md);
  endtask

  task automatic idle();
    req = '0; we = '0; addr = '0; wdata = '0;
    for (int s = 0; s < NS; s++) sdata[s*DW +: DW] = 32'hA5A5_0000 | s;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [3:0]  req, we;
    logic [31:0] base, dbase;
    logic [3:0]  gnt, hold;
    logic [7:0]  swe;
    logic [31:0] saddr, sdata, rd;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int pat[12];
    logic [127:0] e_md;
    int gf, gr;

    tbl[0] = '{4'b1011, 4'b0000, 32'h2000_0000, 32'h1234_5678, 4'b1000, 4'b0011, 8'h00, 32'h0000_0030, 32'h1234_567B, 32'hA5A5_0002};
    tbl[1] = '{4'b0011, 4'b0010, 32'h3000_0100, 32'h0BAD_F00D, 4'b0010, 4'b0001, 8'h08, 32'h0000_0110, 32'h0BAD_F00C, 32'hA5A5_0003};
    tbl[2] = '{4'b0001, 4'b0001, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0001, 4'b0000, 8'h02, 32'h0000_0004, 32'hDEAD_BEEF, 32'hA5A5_0001};
    tbl[3] = '{4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b0000, 8'h00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[4] = '{4'b1111, 4'b1000, 32'h7123_4560, 32'h5555_AAAA, 4'b1000, 4'b0111, 8'h80, 32'h0123_4590, 32'h5555_AAA9, 32'hA5A5_0007};
    tbl[5] = '{4'b0110, 4'b0110, 32'h5000_0000, 32'h0000_1000, 4'b0100, 4'b0010, 8'h20, 32'h0000_0020, 32'h0000_1002, 32'hA5A5_0005};
    pat = '{0, 0, 0, 2, 2, 2, 0, 0, 0, 2, 2, 2};

    rst = 1'b1;
    idle();
    #2;
    chk("rst_gnt_fix", bf.m_gnt_o, 0);
    chk("rst_gnt_rr", br.m_gnt_o, 0);
    chk("rst_swe", {bf.s_we_o, br.s_we_o}, 0);
    chk("rst_saddr", bf.s_addr_o, 0);
    chk("rst_err", {bf.err_o, br.err_o, bf.err_cnt_o, br.err_cnt_o}, 0);
    chk("rst_err_addr", {bf.err_addr_o, br.err_addr_o}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fixed-priority decode table.
    for (int i = 0; i < 6; i++) begin
      req = tbl[i].req; we = tbl[i].we;
      for (int k = 0; k < NM; k++) begin
        addr[k*AW +: AW]  = tbl[i].base + 32'(k * 16);
        wdata[k*DW +: DW] = tbl[i].dbase ^ 32'(k);
      end
      #1;
      e_md = '0;
      for (int k = 0; k < NM; k++) if (tbl[i].gnt[k]) e_md[k*DW +: DW] = tbl[i].rd;
      chk($sformatf("tbl%0d_gnt", i), bf.m_gnt_o, tbl[i].gnt);
      chk($sformatf("tbl%0d_hold", i), bf.m_hold_o, tbl[i].hold);
      chk($sformatf("tbl%0d_swe", i), bf.s_we_o, tbl[i].swe);
      chk($sformatf("tbl%0d_saddr0", i), bf.s_addr_o[0 +: 32], tbl[i].saddr);
      chk($sformatf("tbl%0d_saddr7", i), bf.s_addr_o[7*32 +: 32], tbl[i].saddr);
      chk($sformatf("tbl%0d_sdata", i), bf.s_data_o[3*32 +: 32], tbl[i].sdata);
      chk($sformatf("tbl%0d_mdata", i), bf.m_data_o, e_md);
      @(posedge clk); #1;
    end

    // Unmapped access held for 300 cycles.
    do_reset();
    req = 4'b0001; we = 4'b0001; addr[0 +: 32] = 32'hF000_0000; wdata[0 +: 32] = 32'h1111_2222;
    #1;
    chk("unm_gnt", bf.m_gnt_o, 4'b0001);
    chk("unm_swe", bf.s_we_o, 0);
    chk("unm_mdata", bf.m_data_o, 0);
    chk("unm_err_early", bf.err_o, 0);
    @(posedge clk); #1;
    chk("unm_err", bf.err_o, 1);
    chk("unm_err_addr", bf.err_addr_o, 32'hF000_0000);
    chk("unm_err_cnt1", bf.err_cnt_o, 1);
    repeat (299) @(posedge clk);
    #1;
    chk("unm_err_cnt_sat", bf.err_cnt_o, 255);
    chk("unm_err_held", bf.err_o, 1);
    req = '0;
    @(posedge clk); #1;
    chk("unm_err_clear", bf.err_o, 0);
    chk("unm_cnt_keep", bf.err_cnt_o, 255);

    // Round-robin, masters 0 and 2 continuously requesting.
    do_reset();
    req = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk($sformatf("rr_pat%0d", i), br.m_gnt_o, 4'(1 << pat[i]));
      @(posedge clk); #1;
    end

    // Lone requester saturates tenure, then yields to a newcomer.
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("rr_solo%0d", i), br.m_gnt_o, 4'b0010);
      @(posedge clk); #1;
    end
    req = 4'b1010;
    @(posedge clk); #1;
    chk("rr_newcomer_gnt", br.m_gnt_o, 4'b1000);
    chk("rr_newcomer_hold", br.m_hold_o, 4'b0010);

    // Reset in the middle of a tenure.
    do_reset();
    req = 4'b0100; we = 4'b0100; addr[2*32 +: 32] = 32'h1000_0000;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_gnt_rr", br.m_gnt_o, 0);
    chk("midrst_gnt_fix", bf.m_gnt_o, 0);
    chk("midrst_swe", {br.s_we_o, bf.s_we_o}, 0);
    chk("midrst_hold", br.m_hold_o, 4'b0100);
    @(posedge clk); #1;
    chk("midrst_gnt_edge", br.m_gnt_o, 0);
    req = 4'b1110; we = '0;
    rst = 1'b0;
    #1;
    chk("postrst_first", br.m_gnt_o, 4'b0010);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < NM; k++) begin
        req[k] = ($urandom_range(0, 3) != 0);
        we[k]  = 1'($urandom);
        addr[k*AW +: AW]  = {4'($urandom_range(0, 9)), 28'($urandom)};
        wdata[k*DW +: DW] = $urandom;
      end
      for (int s = 0; s < NS; s++) sdata[s*DW +: DW] = $urandom;
      #1;
      gf = fix_expect(req);
      gr = rr_expect(req);
      check_bus("rnd_fix", gf, bf.m_gnt_o, bf.m_hold_o, bf.s_we_o, bf.s_addr_o[5*32 +: 32], bf.s_data_o[0 +: 32], bf.m_data_o);
      check_bus("rnd_rr", gr, br.m_gnt_o, br.m_hold_o, br.s_we_o, br.s_addr_o[5*32 +: 32], br.s_data_o[0 +: 32], br.m_data_o);
      chk("rnd_fix_err", {bf.err_o, bf.err_cnt_o, bf.err_addr_o}, {1'(e_p[0]), 8'(e_c[0]), e_a[0]});
      chk("rnd_rr_err", {br.err_o, br.err_cnt_o, br.err_addr_o}, {1'(e_p[1]), 8'(e_c[1]), e_a[1]});
      err_commit(0, gf);
      err_commit(1, gr);
      rr_commit(gr);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
